axil_arbiter: RTL and testbench
===============================

AXIL_ARBITER -- requirements
Module: axil_arbiter

Interface
REQ-001 SHALL have no parameters; the master count is fixed at 2 (m0 = IFU, m1 = LSU), with 32-bit address and data.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: m_req  input  2 x axil_req_t  per-master request bundle: aw{addr,valid}, w{data,strb,valid}, bready, ar{addr,valid}, rready.
REQ-005 SHALL have port: m_rsp  output  2 x axil_rsp_t  per-master response bundle: awready, wready, b{resp,valid}, arready, r{data,resp,valid}.
REQ-006 SHALL have port: s_req  output  axil_req_t  request bundle to the shared slave (UART/MMIO).
REQ-007 SHALL have port: s_rsp  input  axil_rsp_t  response bundle from the shared slave.
REQ-008 SHALL have port: grant  output  2  one-hot owner of the slave; 0 when idle.
REQ-009 SHALL have port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 SHALL allow at most one transaction (read or write) outstanding at the slave.
REQ-011 SHALL use FSM states IDLE, AR, R, AWW and B.
REQ-012 SHALL treat master i as requesting when m_req[i].arvalid or m_req[i].awvalid is high.
REQ-013 SHALL arbitrate in IDLE with round-robin: priority goes to the master that is not last_grant; a lone requester wins.
REQ-014 SHALL, when the winner has both awvalid and arvalid high, take the write first (next state AWW); otherwise it takes AR.
REQ-015 SHALL register the arbitration decision: a request seen in IDLE is forwarded to the slave in the following cycle, a fixed 1-cycle arbitration latency.
REQ-016 SHALL, in IDLE, drive all s_req valids and all m_rsp readies/valids to 0.
REQ-017 SHALL, in AR: s.arvalid/araddr = owner's; owner.arready = s.arready; on the s AR handshake, go to R.
REQ-018 SHALL, in R: owner.r* = s.r*; s.rready = owner.rready; on the R handshake, go to IDLE and set last_grant = owner.
REQ-019 SHALL, in AWW, track aw_done and w_done independently: s.awvalid = owner.awvalid & ~aw_done and s.wvalid = owner.wvalid & ~w_done, with readies routed back the same way.
REQ-020 SHALL leave AWW for B once both AW and W have handshaken, whether in the same cycle or in different cycles, in either order.
REQ-021 SHALL, in B: owner.b* = s.b*; s.bready = owner.bready; on the B handshake, go to IDLE, set last_grant = owner and clear the done flags.
REQ-022 SHALL hold all m_rsp outputs of the non-owner at 0 in every state.
REQ-023 SHALL drive payload fields (addr, data, strb) of s_req from the owner in non-IDLE states and to 0 in IDLE.
REQ-024 SHALL pass resp fields through unmodified; the arbiter itself never generates an error response.
REQ-025 SHALL hold grant stable from the arbitration cycle through to the final handshake.
REQ-026 SHALL NOT preempt the owner on a new request from the other master; that request waits until IDLE.
REQ-027 SHALL produce no combinational path from s_rsp to s_req other than the ready/valid pass-through.

Reset
REQ-028 SHALL, while rst is low, force state = IDLE, last_grant = m1 (m0 favoured first), aw_done = w_done = 0, grant = 0 and busy = 0.
REQ-029 SHALL, while rst is low, drive every valid and ready output to 0.
REQ-030 SHALL, on a reset asserted mid-transaction, abandon the transaction with no response issued; resuming is the requester's responsibility.

Structure
REQ-031 SHALL place axil_req_t, axil_rsp_t, the state enum and the RESP_OKAY/RESP_SLVERR constants in the shared package axil_pkg.
REQ-032 SHALL implement the winner pick as the combinational sub-module rr_arb2 (inputs: req[1:0], last; output: one-hot gnt).

Verification
REQ-033 SHALL cover: m0 read 0x1000_0000 alone -> grant=01 one cycle later, s.arvalid one cycle later, rdata 0xDEAD_BEEF returned to m0 only, then IDLE.
REQ-034 SHALL cover: m0 and m1 both arvalid in the same cycle after reset -> m0 served first, then m1; the next simultaneous pair serves m1 first.
REQ-035 SHALL cover: m1 write 0x1000_0000 data 0x41 strb 0x1 with slave AW ready 3 cycles before W -> exactly one AW and one W handshake at the slave, then B OKAY to m1.
REQ-036 SHALL cover: m1 write pending while m0 read in flight with slave rvalid delayed 15 cycles -> m1 sees no readies until m0's R handshake, then is granted.
REQ-037 SHALL cover: rst low during B wait -> grant=0, busy=0, all valids 0 immediately; a fresh m0 read afterwards completes normally.
REQ-038 SHALL cover: the same master holds awvalid and arvalid together -> write completes (B) before the AR is forwarded.

Source files
------------

// File: rtl/axil_pkg.sv
// ---------------------------------------------------------------------------
// axil_pkg
// Shared types for the two-master AXI-Lite arbiter slice.
//   axil_req_t : master-to-slave channel bundle (AW, W, B-ready, AR, R-ready)
//   axil_rsp_t : slave-to-master channel bundle (AW/W ready, B, AR ready, R)
//   state_t    : arbiter FSM encoding with ST_* constants
//   RESP_*     : AXI response codes
// ---------------------------------------------------------------------------
package axil_pkg;

   typedef struct packed {
      logic [31:0] awaddr;
      logic        awvalid;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        wvalid;
      logic        bready;
      logic [31:0] araddr;
      logic        arvalid;
      logic        rready;
   } axil_req_t;

   typedef struct packed {
      logic        awready;
      logic        wready;
      logic [1:0]  bresp;
      logic        bvalid;
      logic        arready;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        rvalid;
   } axil_rsp_t;

   // Arbiter state encoding (kept as plain constants for legacy tools)
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_AR   = 3'd1;
   localparam state_t ST_R    = 3'd2;
   localparam state_t ST_AWW  = 3'd3;
   localparam state_t ST_B    = 3'd4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin winner pick, purely combinational.
//   req  : request bits, one per master
//   last : index of the master that was granted last
//   gnt  : one-hot winner, 0 when nobody requests
// ---------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   // On a tie the master that did not go last wins; a lone requester always wins.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/axil_arbiter.sv
// ---------------------------------------------------------------------------
// axil_arbiter
// Shares one AXI-Lite slave (UART/MMIO) between two masters (m0 = IFU,
// m1 = LSU) with a single outstanding transaction at a time.
//   clk   : clock, all state changes on posedge
//   rst   : asynchronous active-low reset
//   m_req : per-master request bundles
//   m_rsp : per-master response bundles (non-owner always sees zeros)
//   s_req : request bundle to the shared slave
//   s_rsp : response bundle from the shared slave
//   grant : one-hot current owner, 0 when idle
//   busy  : high whenever a transaction is in progress
// ---------------------------------------------------------------------------
module axil_arbiter
   import axil_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  axil_req_t m_req [2],
   output axil_rsp_t m_rsp [2],
   output axil_req_t s_req,
   input  axil_rsp_t s_rsp,
   output logic [1:0] grant,
   output logic      busy
);

   state_t     state;
   logic       owner;
   logic       last_grant;
   logic       aw_done;
   logic       w_done;
   logic [1:0] req_vec;
   logic [1:0] win;
   axil_req_t  sel;
   logic       ar_hs;
   logic       r_hs;
   logic       aw_hs;
   logic       w_hs;
   logic       b_hs;

   assign req_vec[0] = m_req[0].arvalid | m_req[0].awvalid;
   assign req_vec[1] = m_req[1].arvalid | m_req[1].awvalid;

   rr_arb2 u_rr_arb2 (
      .req  (req_vec),
      .last (last_grant),
      .gnt  (win)
   );

   assign sel  = m_req[owner];
   assign busy = (state != ST_IDLE);

   // Handshakes are qualified by the routed valids/readies, which are only
   // non-zero in the state that owns that channel.
   assign ar_hs = s_req.arvalid & s_rsp.arready;
   assign r_hs  = s_rsp.rvalid  & s_req.rready;
   assign aw_hs = s_req.awvalid & s_rsp.awready;
   assign w_hs  = s_req.wvalid  & s_rsp.wready;
   assign b_hs  = s_rsp.bvalid  & s_req.bready;

   // Channel routing: everything defaults to zero so the non-owner and the
   // idle state never see a stray valid or ready. Only the channel belonging
   // to the current state is connected between owner and slave.
   always_comb begin
      s_req    = '0;
      m_rsp[0] = '0;
      m_rsp[1] = '0;
      if (state != ST_IDLE) begin
         s_req.awaddr = sel.awaddr;
         s_req.wdata  = sel.wdata;
         s_req.wstrb  = sel.wstrb;
         s_req.araddr = sel.araddr;
      end
      case (state)
         ST_AR: begin
            s_req.arvalid         = sel.arvalid;
            m_rsp[owner].arready  = s_rsp.arready;
         end
         ST_R: begin
            s_req.rready          = sel.rready;
            m_rsp[owner].rdata    = s_rsp.rdata;
            m_rsp[owner].rresp    = s_rsp.rresp;
            m_rsp[owner].rvalid   = s_rsp.rvalid;
         end
         ST_AWW: begin
            s_req.awvalid         = sel.awvalid & ~aw_done;
            s_req.wvalid          = sel.wvalid  & ~w_done;
            m_rsp[owner].awready  = s_rsp.awready & ~aw_done;
            m_rsp[owner].wready   = s_rsp.wready  & ~w_done;
         end
         ST_B: begin
            s_req.bready          = sel.bready;
            m_rsp[owner].bresp    = s_rsp.bresp;
            m_rsp[owner].bvalid   = s_rsp.bvalid;
         end
         default: ;
      endcase
   end

   // Transaction FSM. The arbitration result is registered in IDLE, so the
   // winner's request reaches the slave one cycle after it was first seen.
   // Writes win over reads when the winner presents both. grant is held from
   // the arbitration cycle until the final handshake, and last_grant is only
   // updated when a transaction completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         grant      <= 2'b00;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win != 2'b00) begin
                  grant <= win;
                  owner <= win[1];
                  state <= m_req[win[1]].awvalid ? ST_AWW : ST_AR;
               end
            end
            ST_AR: begin
               if (ar_hs) state <= ST_R;
            end
            ST_R: begin
               if (r_hs) begin
                  state      <= ST_IDLE;
                  last_grant <= owner;
                  grant      <= 2'b00;
               end
            end
            ST_AWW: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs)  w_done  <= 1'b1;
               if ((aw_done | aw_hs) && (w_done | w_hs)) state <= ST_B;
            end
            ST_B: begin
               if (b_hs) begin
                  state      <= ST_IDLE;
                  last_grant <= owner;
                  grant      <= 2'b00;
                  aw_done    <= 1'b0;
                  w_done     <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axil_arbiter
// Directed bench for axil_arbiter: reset state, lone read, round-robin tie
// breaking, split AW/W write, blocking of a second master during a slow read,
// reset during a B wait, and write-before-read for a master holding both.
// ---------------------------------------------------------------------------
module tb_axil_arbiter;
   import axil_pkg::*;

   logic       clk;
   logic       rst;
   axil_req_t  m_req [2];
   axil_rsp_t  m_rsp [2];
   axil_req_t  s_req;
   axil_rsp_t  s_rsp;
   logic [1:0] grant;
   logic       busy;

   int n_cmp;
   int n_fail;
   int aw_cnt;
   int w_cnt;
   int aw_base;
   int w_base;

   axil_arbiter dut (
      .clk   (clk),
      .rst   (rst),
      .m_req (m_req),
      .m_rsp (m_rsp),
      .s_req (s_req),
      .s_rsp (s_rsp),
      .grant (grant),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts of handshakes seen at the slave side
   initial begin
      aw_cnt = 0;
      w_cnt  = 0;
   end
   always @(posedge clk) begin
      if (s_req.awvalid && s_rsp.awready) aw_cnt = aw_cnt + 1;
      if (s_req.wvalid && s_rsp.wready)   w_cnt  = w_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      assert (obs === exp) else begin
         n_fail = n_fail + 1;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Entered right after the cycle in which the arbiter moved to AR for
   // 'own'; completes AR and R and returns one step into IDLE.
   task automatic serve_read(input int own, input logic [31:0] addr, input logic [31:0] data);
      int oth;
      oth = 1 - own;
      chk("rd_grant", 32'(grant), (own == 0) ? 32'd1 : 32'd2);
      chk("rd_s_arvalid", 32'(s_req.arvalid), 32'd1);
      chk("rd_s_araddr", s_req.araddr, addr);
      s_rsp.arready = 1'b1;
      #1;
      chk("rd_own_arready", 32'(m_rsp[own].arready), 32'd1);
      chk("rd_oth_arready", 32'(m_rsp[oth].arready), 32'd0);
      tick();
      s_rsp.arready      = 1'b0;
      m_req[own].arvalid = 1'b0;
      s_rsp.rvalid       = 1'b1;
      s_rsp.rdata        = data;
      #1;
      chk("rd_s_arvalid_in_r", 32'(s_req.arvalid), 32'd0);
      chk("rd_own_rvalid", 32'(m_rsp[own].rvalid), 32'd1);
      chk("rd_own_rdata", m_rsp[own].rdata, data);
      chk("rd_oth_rvalid", 32'(m_rsp[oth].rvalid), 32'd0);
      chk("rd_oth_rdata", m_rsp[oth].rdata, 32'd0);
      chk("rd_s_rready", 32'(s_req.rready), 32'd1);
      tick();
      s_rsp.rvalid = 1'b0;
      s_rsp.rdata  = 32'd0;
      #1;
      chk("rd_done_busy", 32'(busy), 32'd0);
      chk("rd_done_grant", 32'(grant), 32'd0);
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      m_req[0] = '0;
      m_req[1] = '0;
      s_rsp    = '0;
      rst      = 1'b1;
      #2;
      rst = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_s_arvalid", 32'(s_req.arvalid), 32'd0);
      chk("rst_s_awvalid", 32'(s_req.awvalid), 32'd0);
      chk("rst_m0_arready", 32'(m_rsp[0].arready), 32'd0);

      rst = 1'b1;
      m_req[0].rready = 1'b1;
      m_req[1].rready = 1'b1;
      m_req[0].bready = 1'b1;
      m_req[1].bready = 1'b1;
      tick();

      // Lone m0 read, forwarded one cycle after it is seen
      $display("[TB] lone m0 read");
      m_req[0].araddr  = 32'h1000_0000;
      m_req[0].arvalid = 1'b1;
      #1;
      chk("t1_idle_grant", 32'(grant), 32'd0);
      chk("t1_idle_s_arvalid", 32'(s_req.arvalid), 32'd0);
      chk("t1_idle_s_araddr", s_req.araddr, 32'd0);
      chk("t1_idle_m0_arready", 32'(m_rsp[0].arready), 32'd0);
      tick();
      serve_read(0, 32'h1000_0000, 32'hDEAD_BEEF);

      // Simultaneous reads after reset: m0 first, then the next tie goes to m1
      $display("[TB] round-robin reads");
      rst = 1'b0;
      tick();
      rst = 1'b1;
      m_req[0].araddr  = 32'h0000_0100;
      m_req[0].arvalid = 1'b1;
      m_req[1].araddr  = 32'h0000_0200;
      m_req[1].arvalid = 1'b1;
      tick();
      serve_read(0, 32'h0000_0100, 32'h0000_0111);
      m_req[0].araddr  = 32'h0000_0300;
      m_req[0].arvalid = 1'b1;
      tick();
      serve_read(1, 32'h0000_0200, 32'h0000_0222);
      tick();
      serve_read(0, 32'h0000_0300, 32'h0000_0333);

      // m1 write, slave takes AW three cycles before W
      $display("[TB] m1 split write");
      aw_base = aw_cnt;
      w_base  = w_cnt;
      m_req[1].awaddr  = 32'h1000_0000;
      m_req[1].wdata   = 32'h0000_0041;
      m_req[1].wstrb   = 4'h1;
      m_req[1].awvalid = 1'b1;
      m_req[1].wvalid  = 1'b1;
      tick();
      chk("t3_grant", 32'(grant), 32'd2);
      chk("t3_s_awaddr", s_req.awaddr, 32'h1000_0000);
      chk("t3_s_wdata", s_req.wdata, 32'h0000_0041);
      chk("t3_s_wstrb", 32'(s_req.wstrb), 32'd1);
      chk("t3_s_awvalid", 32'(s_req.awvalid), 32'd1);
      chk("t3_s_wvalid", 32'(s_req.wvalid), 32'd1);
      s_rsp.awready = 1'b1;
      #1;
      chk("t3_m1_awready", 32'(m_rsp[1].awready), 32'd1);
      chk("t3_m1_wready", 32'(m_rsp[1].wready), 32'd0);
      chk("t3_m0_awready", 32'(m_rsp[0].awready), 32'd0);
      tick();
      chk("t3_aw_masked", 32'(s_req.awvalid), 32'd0);
      chk("t3_m1_awready_masked", 32'(m_rsp[1].awready), 32'd0);
      chk("t3_wvalid_held", 32'(s_req.wvalid), 32'd1);
      chk("t3_busy", 32'(busy), 32'd1);
      tick();
      tick();
      s_rsp.wready = 1'b1;
      #1;
      chk("t3_m1_wready", 32'(m_rsp[1].wready), 32'd1);
      tick();
      s_rsp.awready = 1'b0;
      s_rsp.wready  = 1'b0;
      #1;
      chk("t3_aw_count", 32'(aw_cnt - aw_base), 32'd1);
      chk("t3_w_count", 32'(w_cnt - w_base), 32'd1);
      chk("t3_s_wvalid_in_b", 32'(s_req.wvalid), 32'd0);
      chk("t3_s_bready", 32'(s_req.bready), 32'd1);
      s_rsp.bvalid = 1'b1;
      s_rsp.bresp  = RESP_OKAY;
      #1;
      chk("t3_m1_bvalid", 32'(m_rsp[1].bvalid), 32'd1);
      chk("t3_m1_bresp", 32'(m_rsp[1].bresp), 32'(RESP_OKAY));
      chk("t3_m0_bvalid", 32'(m_rsp[0].bvalid), 32'd0);
      m_req[1].awvalid = 1'b0;
      m_req[1].wvalid  = 1'b0;
      tick();
      s_rsp.bvalid = 1'b0;
      #1;
      chk("t3_done_busy", 32'(busy), 32'd0);

      // m1 write waits behind a slow m0 read
      $display("[TB] m1 write blocked by slow m0 read");
      m_req[0].araddr  = 32'h0000_2000;
      m_req[0].arvalid = 1'b1;
      m_req[1].awaddr  = 32'h0000_3000;
      m_req[1].wdata   = 32'h0000_0055;
      m_req[1].wstrb   = 4'hF;
      m_req[1].awvalid = 1'b1;
      m_req[1].wvalid  = 1'b1;
      tick();
      chk("t4_grant_m0", 32'(grant), 32'd1);
      s_rsp.arready = 1'b1;
      #1;
      chk("t4_m1_awready_ar", 32'(m_rsp[1].awready), 32'd0);
      tick();
      s_rsp.arready    = 1'b0;
      m_req[0].arvalid = 1'b0;
      s_rsp.awready    = 1'b1;
      s_rsp.wready     = 1'b1;
      #1;
      for (int i = 0; i < 15; i++) begin
         chk("t4_hold_grant", 32'(grant), 32'd1);
         chk("t4_m1_awready", 32'(m_rsp[1].awready), 32'd0);
         chk("t4_m1_wready", 32'(m_rsp[1].wready), 32'd0);
         chk("t4_s_awvalid", 32'(s_req.awvalid), 32'd0);
         tick();
      end
      s_rsp.rvalid = 1'b1;
      s_rsp.rdata  = 32'h0000_5A5A;
      #1;
      chk("t4_m0_rvalid", 32'(m_rsp[0].rvalid), 32'd1);
      chk("t4_m1_awready_r", 32'(m_rsp[1].awready), 32'd0);
      tick();
      s_rsp.rvalid = 1'b0;
      s_rsp.rdata  = 32'd0;
      #1;
      chk("t4_idle_grant", 32'(grant), 32'd0);
      tick();
      chk("t4_grant_m1", 32'(grant), 32'd2);
      chk("t4_m1_awready_now", 32'(m_rsp[1].awready), 32'd1);
      chk("t4_m1_wready_now", 32'(m_rsp[1].wready), 32'd1);
      chk("t4_s_awaddr", s_req.awaddr, 32'h0000_3000);
      tick();
      m_req[1].awvalid = 1'b0;
      m_req[1].wvalid  = 1'b0;
      s_rsp.awready    = 1'b0;
      s_rsp.wready     = 1'b0;
      s_rsp.bvalid     = 1'b1;
      s_rsp.bresp      = RESP_SLVERR;
      #1;
      chk("t4_m1_bresp", 32'(m_rsp[1].bresp), 32'(RESP_SLVERR));
      chk("t4_busy_b", 32'(busy), 32'd1);
      tick();
      s_rsp.bvalid = 1'b0;
      s_rsp.bresp  = RESP_OKAY;

      // Reset while waiting for B
      $display("[TB] reset during B wait");
      m_req[0].awaddr  = 32'h0000_4000;
      m_req[0].wdata   = 32'h0000_0044;
      m_req[0].wstrb   = 4'h1;
      m_req[0].awvalid = 1'b1;
      m_req[0].wvalid  = 1'b1;
      tick();
      s_rsp.awready = 1'b1;
      s_rsp.wready  = 1'b1;
      tick();
      s_rsp.awready = 1'b0;
      s_rsp.wready  = 1'b0;
      #1;
      chk("t5_s_bready", 32'(s_req.bready), 32'd1);
      tick();
      tick();
      rst          = 1'b0;
      s_rsp.bvalid = 1'b1;
      #1;
      chk("t5_grant", 32'(grant), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_s_bready", 32'(s_req.bready), 32'd0);
      chk("t5_m0_bvalid", 32'(m_rsp[0].bvalid), 32'd0);
      chk("t5_s_awvalid", 32'(s_req.awvalid), 32'd0);
      chk("t5_s_wvalid", 32'(s_req.wvalid), 32'd0);
      m_req[0].awvalid = 1'b0;
      m_req[0].wvalid  = 1'b0;
      s_rsp.bvalid     = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      m_req[0].araddr  = 32'h1000_0004;
      m_req[0].arvalid = 1'b1;
      tick();
      serve_read(0, 32'h1000_0004, 32'hCAFE_F00D);

      // Same master holds AW and AR: write completes before the read
      $display("[TB] write before read for one master");
      m_req[0].awaddr  = 32'h0000_5000;
      m_req[0].wdata   = 32'h0000_0077;
      m_req[0].wstrb   = 4'h3;
      m_req[0].awvalid = 1'b1;
      m_req[0].wvalid  = 1'b1;
      m_req[0].araddr  = 32'h0000_6000;
      m_req[0].arvalid = 1'b1;
      tick();
      chk("t6_grant", 32'(grant), 32'd1);
      chk("t6_s_awvalid", 32'(s_req.awvalid), 32'd1);
      chk("t6_s_wvalid", 32'(s_req.wvalid), 32'd1);
      chk("t6_s_arvalid_aww", 32'(s_req.arvalid), 32'd0);
      s_rsp.awready = 1'b1;
      s_rsp.wready  = 1'b1;
      tick();
      s_rsp.awready    = 1'b0;
      s_rsp.wready     = 1'b0;
      m_req[0].awvalid = 1'b0;
      m_req[0].wvalid  = 1'b0;
      s_rsp.bvalid     = 1'b1;
      #1;
      chk("t6_s_arvalid_b", 32'(s_req.arvalid), 32'd0);
      chk("t6_m0_bvalid", 32'(m_rsp[0].bvalid), 32'd1);
      chk("t6_m0_arready_b", 32'(m_rsp[0].arready), 32'd0);
      tick();
      s_rsp.bvalid = 1'b0;
      #1;
      chk("t6_idle_s_arvalid", 32'(s_req.arvalid), 32'd0);
      tick();
      serve_read(0, 32'h0000_6000, 32'h0000_6666);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
